// File: rtl/vga_line_fetch.sv
// rtl/vga_line_fetch.sv - ping-pong line prefetch from frame memory for the VGA output path
module vga_line_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              c25,
  input  logic              Reset,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [17:0]       pixel_out,
  output logic              underrun
);

  localparam int COL_W = $clog2(H_ACTIVE);

  typedef enum logic [1:0] {PRIME, IDLE, FETCH} state_t;

  state_t           state;
  logic [9:0]       prev_y;
  logic [9:0]       tgt;
  logic [COL_W-1:0] col;
  logic [1:0]       valid;
  logic [7:0]       line_buf [2][H_ACTIVE];

  logic             new_line;
  logic             start_fetch;
  logic             wr_en;
  logic             last_col;
  logic             rd_ok;
  logic [7:0]       rd_pix;
  logic [9:0]       next_tgt;
  logic [ADDR_W-1:0] next_base;

  assign new_line    = (disp_y != prev_y) && (disp_y < 10'(V_ACTIVE));
  assign next_tgt    = (disp_y == 10'(V_ACTIVE - 1)) ? 10'd0 : disp_y + 10'd1;
  assign next_base   = ADDR_W'(next_tgt) * ADDR_W'(H_ACTIVE);
  assign start_fetch = new_line && (state == IDLE || state == FETCH);
  assign last_col    = (col == COL_W'(H_ACTIVE - 1));
  // A line change always wins over an ack arriving on the same cycle.
  assign wr_en       = (state == FETCH) && mem_ack && !new_line;

  // Display line and target line always have opposite parity, so the
  // read buffer is never the one being written.
  assign rd_ok  = (disp_y < 10'(V_ACTIVE)) && (disp_x < 10'(H_ACTIVE)) && valid[disp_y[0]];
  assign rd_pix = line_buf[disp_y[0]][disp_x];

  always_ff @(posedge c25) begin
    if (wr_en) line_buf[tgt[0]][col] <= mem_data;
  end

  always_ff @(posedge c25 or negedge Reset) begin
    if (!Reset) begin
      state     <= PRIME;
      prev_y    <= '0;
      tgt       <= '0;
      col       <= '0;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      pixel_out <= '0;
      underrun  <= 1'b0;
    end else begin
      prev_y    <= disp_y;
      pixel_out <= rd_ok ? {10'd0, rd_pix} : 18'd0;
      if (state == PRIME) begin
        state    <= FETCH;
        tgt      <= '0;
        col      <= '0;
        mem_addr <= '0;
        mem_req  <= 1'b1;
        valid[0] <= 1'b0;
      end else if (start_fetch) begin
        // Entering here from FETCH means the previous fetch missed its line.
        if (state == FETCH) underrun <= 1'b1;
        state            <= FETCH;
        tgt              <= next_tgt;
        col              <= '0;
        mem_addr         <= next_base;
        mem_req          <= 1'b1;
        valid[next_tgt[0]] <= 1'b0;
      end else if (state == FETCH && mem_ack) begin
        if (last_col) begin
          valid[tgt[0]] <= 1'b1;
          mem_req       <= 1'b0;
          state         <= IDLE;
        end else begin
          col      <= col + COL_W'(1);
          mem_addr <= mem_addr + ADDR_W'(1);
        end
      end else if (state != IDLE && state != FETCH) begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb/tb_vga_line_fetch.sv - randomized scoreboard bench for vga_line_fetch
`timescale 1ns/1ps
module tb_vga_line_fetch;
  localparam int H = 640;
  localparam int V = 480;

  logic        c25 = 1'b0;
  logic        Reset = 1'b0;
  logic [9:0]  disp_x = '0;
  logic [9:0]  disp_y = 10'd480;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data;
  logic [17:0] pixel_out;
  logic        underrun;

  always #20 c25 = ~c25;

  vga_line_fetch dut (
    .c25(c25), .Reset(Reset), .disp_x(disp_x), .disp_y(disp_y),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .pixel_out(pixel_out), .underrun(underrun)
  );

  function automatic logic [7:0] dat(input int a);
    return 8'(a ^ (a >> 9));
  endfunction

  // Frame memory: contents are a fixed function of the address presented.
  assign mem_data = dat(int'(mem_addr));

  typedef struct {
    int edge_no;
    int pix;
    bit req;
    int addr;
    bit und;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_r;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  logic [7:0] m_buf [2][H];
  bit   m_valid [2];
  bit   m_busy, m_und, m_prime;
  int   m_line, m_col, m_prev_y;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, edge_cnt, act, req);
    end
  endtask

  always @(posedge c25) edge_cnt++;

  always @(negedge c25) begin
    if (Reset && exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
      mon_r = exp_q.pop_front();
      chk("pixel_out", int'(pixel_out), mon_r.pix);
      chk("mem_req", int'(mem_req), int'(mon_r.req));
      if (mon_r.req) chk("mem_addr", int'(mem_addr), mon_r.addr);
      chk("underrun", int'(underrun), int'(mon_r.und));
    end
  end

  task automatic model_start(input int t);
    m_busy = 1'b1;
    m_line = t;
    m_col  = 0;
    m_valid[t % 2] = 1'b0;
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input int x, input int y, input bit ack);
    rec_t r;
    int   pix;
    bit   nl;
    disp_x  = 10'(x);
    disp_y  = 10'(y);
    mem_ack = ack;
    pix = (y < V && x < H && m_valid[y % 2]) ? int'(m_buf[y % 2][x]) : 0;
    if (m_prime) begin
      m_prime = 1'b0;
      model_start(0);
    end else begin
      nl = (y != m_prev_y) && (y < V);
      if (nl) begin
        if (m_busy) m_und = 1'b1;
        model_start(y == V - 1 ? 0 : y + 1);
      end else if (m_busy && ack) begin
        m_buf[m_line % 2][m_col] = dat(m_line * H + m_col);
        m_col++;
        if (m_col == H) begin
          m_valid[m_line % 2] = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
    m_prev_y  = y;
    r.edge_no = edge_cnt + 1;
    r.pix     = pix;
    r.req     = m_busy;
    r.addr    = m_line * H + m_col;
    r.und     = m_und;
    exp_q.push_back(r);
    @(posedge c25);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst mem_req", int'(mem_req), 0);
    chk("rst mem_addr", int'(mem_addr), 0);
    chk("rst pixel_out", int'(pixel_out), 0);
    chk("rst underrun", int'(underrun), 0);
  endtask

  task automatic reset_pulse(input int n);
    Reset = 1'b0;
    #1;
    chk_reset_outputs();
    m_busy = 1'b0; m_und = 1'b0; m_prime = 1'b1; m_prev_y = 0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    exp_q.delete();
    repeat (n) begin
      @(posedge c25);
      #1;
      chk_reset_outputs();
    end
    Reset = 1'b1;
  endtask

  function automatic bit ack_of(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 3) == 2;
      2:       return (i % 2) == 1;
      default: return $urandom_range(0, 9) != 0;
    endcase
  endfunction

  task automatic run_line(input int y, input int len, input int mode, input bit xrand);
    int x;
    for (int i = 0; i < len; i++) begin
      x = xrand ? int'($urandom_range(0, 700)) : (i < 1023 ? i : 1023);
      step(x, y, ack_of(mode, i));
    end
  endtask

  initial begin
    mem_ack = 1'b1;
    #1;
    reset_pulse(4);
    run_line(480, 660, 0, 1'b0);   // prime with back-to-back acks
    run_line(0, 800, 3, 1'b0);
    run_line(1, 2000, 1, 1'b0);    // ack every third cycle
    run_line(2, 800, 3, 1'b1);
    run_line(479, 800, 0, 1'b1);   // wrap: line 0 refetched
    for (int y = 480; y < 490; y++) run_line(y, 40, 3, 1'b1);
    run_line(0, 800, 3, 1'b1);
    run_line(1, 800, 2, 1'b0);     // half-rate memory forces overruns
    run_line(2, 800, 2, 1'b1);
    run_line(3, 800, 2, 1'b1);
    run_line(4, 300, 0, 1'b0);     // reset lands mid-fetch
    reset_pulse(3);
    run_line(480, 720, 3, 1'b0);
    run_line(0, 800, 0, 1'b1);
    @(negedge c25);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Upstream pixel source for the VGA output wrapper. Tracks the display coordinates from vga_template (dispX/dispY) and prefetches the next visible line from an external frame memory into a ping-pong line buffer.
- Memory access is a req/ack handshake; pixels are RGB332, one byte per pixel.
- Presents the current pixel on an 18-bit bus that connects directly to the wrapper's pixel_in.

Parameters:
H_ACTIVE, 640, visible pixels per line (must be even)
V_ACTIVE, 480, visible lines per frame (must be even)
ADDR_W, 19, frame memory address width

Ports:
c25  input  1  pixel clock, 25 MHz
Reset  input  1  asynchronous, active-low reset
disp_x  input  10  current display column from the timing generator
disp_y  input  10  current display line; values >= V_ACTIVE mean vertical blank
mem_req  output  1  fetch request, held until acknowledged
mem_addr  output  ADDR_W  pixel address = line*H_ACTIVE + column
mem_ack  input  1  memory has mem_data valid for the current mem_addr this cycle
mem_data  input  8  RGB332 pixel, bits [7:5]=R, [4:2]=G, [1:0]=B
pixel_out  output  18  [7:0]=RGB332 pixel, [17:8]=0
underrun  output  1  sticky: a line was displayed before its fetch completed

Behaviour:
- Reset (Reset=0, asynchronous):
  - mem_req=0, mem_addr=0, pixel_out=0, underrun=0.
  - Both buffer-valid flags=0, prev_y=0, state=PRIME.
- Storage: buf[0], buf[1], each H_ACTIVE x 8. Line L is stored in buf[L[0]].
- Line-change detect:
  - prev_y registers disp_y each cycle.
  - new_line = (disp_y != prev_y) && (disp_y < V_ACTIVE).
  - Target line T = (disp_y == V_ACTIVE-1) ? 0 : disp_y+1.
- States:
  - PRIME: entered only from reset. Begins a fetch of line 0 into buf[0] on the first clock after Reset deasserts, then goes to FETCH.
  - IDLE: mem_req=0. On new_line: start a fetch of T and go to FETCH.
  - FETCH:
    - mem_req=1 and mem_addr = T*H_ACTIVE + col, starting at col=0.
    - Addr is stable while ack=0.
    - On a cycle with mem_ack=1: write mem_data to buf[T[0]][col], then col++.
    - Req stays high, so back-to-back acks give one pixel per cycle.
    - After the ack at col=H_ACTIVE-1: set valid[T[0]]=1, drop mem_req on the next cycle, go to IDLE.
- Fetch start (any state): clears valid[T[0]] and sets col=0.
- new_line while in FETCH (overrun of the previous fetch):
  - Set underrun=1.
  - Abandon the current fetch; its buffer stays invalid.
  - Restart immediately with the new T. No idle cycle; mem_addr jumps to T*H_ACTIVE.
- mem_ack while mem_req=0 is ignored.
- Display read (1-cycle registered latency): pixel_out[7:0] at cycle n+1 is:
  - buf[disp_y[0]][disp_x] at cycle n, when disp_y < V_ACTIVE, disp_x < H_ACTIVE and valid[disp_y[0]]=1;
  - 0x00 otherwise.
  - pixel_out[17:8] is always 0.
- Read and write never target the same buffer, because T parity always differs from disp_y parity (V_ACTIVE even).
- Bandwidth: a fetch needs H_ACTIVE acks within one line period. At 800 clocks per line there are 160 stall cycles of slack.
- underrun is cleared only by reset.

Test Plan:
1. Reset with mem_ack tied high and mem_data=mem_addr[7:0]; release Reset -> mem_req=1 next cycle, mem_addr steps 0..639 on consecutive cycles, mem_req=0 after addr 639; all outputs 0 while Reset=0.
2. Drive disp_y=0, disp_x=0..639 after the prime -> pixel_out = {10'b0, x[7:0]} one cycle after each x. At the first disp_y=0 cycle, mem_addr=640 and mem_req=1 (line 1 fetch).
3. Wait states: ack every 3rd cycle -> mem_addr holds for 3 cycles per pixel and no pixel is skipped; line 1 contents equal (640+x)[7:0].
4. disp_y=479 -> fetch targets line 0: mem_addr restarts at 0 into buf[0]. disp_y=480..524 -> pixel_out=0 and mem_req stays 0.
5. ack only every 2nd cycle, 800-clock lines -> new_line arrives at col≈400; underrun goes 1 and stays 1; the restarted fetch's mem_addr jumps to the new T*640; the aborted line displays 0x00.
6. Assert Reset mid-FETCH at col=300 -> mem_req=0, pixel_out=0, underrun=0 the same cycle; after release, PRIME refetches from mem_addr=0.
